// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and the twiddle-index helper for the
// 2048-point NTT address generator.
package ntt_pkg;

  localparam int LOGN    = 11;
  localparam int N       = 2048;
  localparam int ADDR_W  = 11;
  localparam int BADDR_W = 9;
  localparam int TW_W    = 10;
  localparam int B_W     = 10;
  localparam int S_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  // Low s bits of the butterfly index, left-aligned into the 10-bit twiddle field.
  function automatic logic [TW_W-1:0] tw_index(input logic [B_W-1:0] b,
                                               input logic [S_W-1:0] s);
    logic [B_W-1:0]      mask;
    logic [2*TW_W-1:0]   wide;
    mask = (B_W'(1) << s) - B_W'(1);
    wide = {{TW_W{1'b0}}, b & mask} << (TW_W - int'(s));
    return wide[TW_W-1:0];
  endfunction

endpackage

// File: rtl/ntt_addr_gen_if.sv
// Beat bus between the NTT address generator and its consumer (cfmm).
interface ntt_addr_gen_if;
  import ntt_pkg::*;

  // A beat transfers on a rising clk edge where out_valid && out_ready; while
  // out_valid is high and out_ready is low, every beat field holds stable and
  // out_valid never drops before the transfer.
  logic              start;
  logic              inv;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] oldadd0;
  logic [ADDR_W-1:0] oldadd1;
  logic [ADDR_W-1:0] oldadd2;
  logic [ADDR_W-1:0] oldadd3;
  logic [TW_W-1:0]   tw0;
  logic [TW_W-1:0]   tw1;
  logic [S_W-1:0]    stage;
  logic              last;
  logic              done;
  state_t            fsm_state;

  modport master (
    input  start, inv, out_ready,
    output busy, out_valid, oldadd0, oldadd1, oldadd2, oldadd3,
    output tw0, tw1, stage, last, done, fsm_state
  );

  modport slave (
    output start, inv, out_ready,
    input  busy, out_valid, oldadd0, oldadd1, oldadd2, oldadd3,
    input  tw0, tw1, stage, last, done, fsm_state
  );

endinterface

// File: rtl/ntt_bit_insert.sv
// Inserts bit x at position s of a 10-bit butterfly index, giving the 11-bit
// coefficient address of one butterfly operand.
module ntt_bit_insert
  import ntt_pkg::*;
(
  input  logic [B_W-1:0]    b,
  input  logic [S_W-1:0]    s,
  input  logic              x,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] bw;
  logic [ADDR_W-1:0] hi;
  logic [ADDR_W-1:0] lo_mask;
  logic [ADDR_W-1:0] xbit;

  always_comb begin
    bw      = {1'b0, b};
    lo_mask = (ADDR_W'(1) << s) - ADDR_W'(1);
    hi      = (bw >> s) << (s + 4'd1);
    xbit    = ADDR_W'(x) << s;
    addr    = hi | xbit | (bw & lo_mask);
  end

endmodule

// File: rtl/ntt_addr_gen.sv
// Per-cycle address/twiddle generator: four operand addresses and two twiddle
// indices per beat, 512 beats per stage, 11 stages, optional inter-stage gap.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int LOGN = 11,
  parameter int GAP  = 4
) (
  input logic            clk,
  input logic            rst,
  ntt_addr_gen_if.master bus
);

  localparam int KW = LOGN - 2;
  localparam int BW = LOGN - 1;
  localparam int GW = $clog2(GAP + 2);
  localparam logic [KW-1:0]  K_END   = '1;
  localparam logic [S_W-1:0] S_TOP   = S_W'(LOGN - 1);
  localparam logic [GW-1:0]  GAP_END = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t            state_q;
  state_t            state_d;
  logic [S_W-1:0]    s_q;
  logic [S_W-1:0]    ld_s;
  logic [S_W-1:0]    s_step;
  logic [KW-1:0]     k_q;
  logic [KW-1:0]     ld_k;
  logic [GW-1:0]     gap_q;
  logic              inv_q;
  logic              hs;
  logic              accept;
  logic              load;
  logic              enter_gap;
  logic              finish;
  logic              busy_q;
  logic              valid_q;
  logic              last_q;
  logic              done_q;
  logic [BW-1:0]     b0;
  logic [BW-1:0]     b1;
  logic [ADDR_W-1:0] a0_d, a1_d, a2_d, a3_d;
  logic [ADDR_W-1:0] a0_q, a1_q, a2_q, a3_q;
  logic [TW_W-1:0]   t0_d, t1_d;
  logic [TW_W-1:0]   t0_q, t1_q;

  // Next-state logic; "load" means the beat described by (ld_s, ld_k) is
  // registered onto the outputs at the coming edge.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load      = 1'b0;
    enter_gap = 1'b0;
    finish    = 1'b0;
    ld_s      = s_q;
    ld_k      = k_q;
    hs        = valid_q && bus.out_ready;
    s_step    = inv_q ? (s_q - 4'd1) : (s_q + 4'd1);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          load    = 1'b1;
          ld_s    = bus.inv ? S_TOP : '0;
          ld_k    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          if (k_q != K_END) begin
            load = 1'b1;
            ld_k = k_q + KW'(1);
          end else if (inv_q ? (s_q == '0) : (s_q == S_TOP)) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else if (GAP == 0) begin
            load = 1'b1;
            ld_s = s_step;
            ld_k = '0;
          end else begin
            enter_gap = 1'b1;
            state_d   = ntt_pkg::GAP;
          end
        end
      end
      ntt_pkg::GAP: begin
        if (gap_q == GAP_END) begin
          load    = 1'b1;
          ld_s    = s_step;
          ld_k    = '0;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign b0   = {ld_k, 1'b0};
  assign b1   = {ld_k, 1'b1};
  assign t0_d = tw_index(b0, ld_s);
  assign t1_d = tw_index(b1, ld_s);

  ntt_bit_insert u_ins0 (.b(b0), .s(ld_s), .x(1'b0), .addr(a0_d));
  ntt_bit_insert u_ins1 (.b(b0), .s(ld_s), .x(1'b1), .addr(a1_d));
  ntt_bit_insert u_ins2 (.b(b1), .s(ld_s), .x(1'b0), .addr(a2_d));
  ntt_bit_insert u_ins3 (.b(b1), .s(ld_s), .x(1'b1), .addr(a3_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      k_q     <= '0;
      gap_q   <= '0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      a0_q    <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
    end else begin
      done_q <= finish;
      if (accept) inv_q <= bus.inv;
      if (load) begin
        s_q     <= ld_s;
        k_q     <= ld_k;
        busy_q  <= 1'b1;
        valid_q <= 1'b1;
        last_q  <= (ld_k == K_END);
        a0_q    <= a0_d;
        a1_q    <= a1_d;
        a2_q    <= a2_d;
        a3_q    <= a3_d;
        t0_q    <= t0_d;
        t1_q    <= t1_d;
      end
      // Addresses and stage hold through the gap; only the qualifiers drop.
      if (enter_gap) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        gap_q   <= '0;
      end
      if (state_q == ntt_pkg::GAP) gap_q <= gap_q + GW'(1);
      if (finish) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        busy_q  <= 1'b0;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = valid_q;
  assign bus.oldadd0   = a0_q;
  assign bus.oldadd1   = a1_q;
  assign bus.oldadd2   = a2_q;
  assign bus.oldadd3   = a3_q;
  assign bus.tw0       = t0_q;
  assign bus.tw1       = t1_q;
  assign bus.stage     = s_q;
  assign bus.last      = last_q;
  assign bus.done      = done_q;
  assign bus.fsm_state = state_q;

endmodule
